// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode/condition macros and the arbiter's common types.
`ifndef ALU_DEFS_SV
`define ALU_DEFS_SV
`define ALUOP_RANGE 3:0
`define ALUOP_ADD  4'd0
`define ALUOP_SUB  4'd1
`define ALUOP_AND  4'd2
`define ALUOP_OR   4'd3
`define ALUOP_XOR  4'd4
`define ALUOP_SLL  4'd5
`define ALUOP_SRL  4'd6
`define ALUOP_SRA  4'd7
`define ALUOP_SLT  4'd8
`define ALUOP_SLTU 4'd9
`define ALUCOND_EQ  3'd0
`define ALUCOND_NE  3'd1
`define ALUCOND_LT  3'd4
`define ALUCOND_GE  3'd5
`define ALUCOND_LTU 3'd6
`define ALUCOND_GEU 3'd7
`define ALUARB_NREQ 2
`endif

package alu_arbiter_pkg;
    localparam int NREQ = `ALUARB_NREQ;
    typedef logic [NREQ-1:0] req_vec_t;
    typedef logic [`ALUOP_RANGE] aluop_t;
    typedef logic [2:0] alucond_t;
endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester other than
// the last winner is granted.
module rr_arbiter2
    import alu_arbiter_pkg::*;
(
    input  logic     en,
    input  req_vec_t valid,
    input  logic     last,
    output req_vec_t grant
);
    always_comb begin
        grant = '0;
        if (en) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters with round-robin
// arbitration and per-requester response routing.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  req_vec_t          req_valid_i,
    output req_vec_t          req_ready_o,
    input  logic [C_XLEN-1:0] req0_op_left_i,
    input  logic [C_XLEN-1:0] req0_op_right_i,
    input  aluop_t            req0_op_opcode_i,
    input  logic [C_XLEN-1:0] req0_cmp_left_i,
    input  logic [C_XLEN-1:0] req0_cmp_right_i,
    input  alucond_t          req0_cmp_opcode_i,
    input  logic [C_XLEN-1:0] req1_op_left_i,
    input  logic [C_XLEN-1:0] req1_op_right_i,
    input  aluop_t            req1_op_opcode_i,
    input  logic [C_XLEN-1:0] req1_cmp_left_i,
    input  logic [C_XLEN-1:0] req1_cmp_right_i,
    input  alucond_t          req1_cmp_opcode_i,
    output logic              alu_clk_en_o,
    output logic [C_XLEN-1:0] alu_op_left_o,
    output logic [C_XLEN-1:0] alu_op_right_o,
    output aluop_t            alu_op_opcode_o,
    output logic [C_XLEN-1:0] alu_cmp_left_o,
    output logic [C_XLEN-1:0] alu_cmp_right_o,
    output alucond_t          alu_cmp_opcode_o,
    input  logic [C_XLEN-1:0] alu_op_result_i,
    input  logic              alu_cmp_result_i,
    output req_vec_t          rsp_valid_o,
    input  req_vec_t          rsp_ready_i,
    output logic [C_XLEN-1:0] rsp_op_result_o,
    output logic              rsp_cmp_result_o
);
    logic     rsp_valid_q;
    logic     rsp_owner_q;
    logic     last_grant_q;
    logic     owner_ready;
    logic     slot_free;
    logic     can_issue;
    logic     issue;
    logic     grant_id;
    req_vec_t grant;

    assign owner_ready = rsp_ready_i[rsp_owner_q];
    assign slot_free   = ~rsp_valid_q | owner_ready;
    // Qualified by reset so nothing is granted or clocked while held in reset.
    assign can_issue   = clk_en_i & slot_free & resetb_i;

    rr_arbiter2 u_rr (
        .en    (can_issue),
        .valid (req_valid_i),
        .last  (last_grant_q),
        .grant (grant)
    );

    assign issue       = |grant;
    assign grant_id    = grant[1];
    assign req_ready_o = grant;

    always_comb begin
        alu_op_left_o    = req0_op_left_i;
        alu_op_right_o   = req0_op_right_i;
        alu_op_opcode_o  = req0_op_opcode_i;
        alu_cmp_left_o   = req0_cmp_left_i;
        alu_cmp_right_o  = req0_cmp_right_i;
        alu_cmp_opcode_o = req0_cmp_opcode_i;
        if (grant_id) begin
            alu_op_left_o    = req1_op_left_i;
            alu_op_right_o   = req1_op_right_i;
            alu_op_opcode_o  = req1_op_opcode_i;
            alu_cmp_left_o   = req1_cmp_left_i;
            alu_cmp_right_o  = req1_cmp_right_i;
            alu_cmp_opcode_o = req1_cmp_opcode_i;
        end
    end

    // Freezing the ALU register keeps an unaccepted result on the bus.
    assign alu_clk_en_o = can_issue;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (clk_en_i) begin
            if (issue) begin
                rsp_valid_q  <= 1'b1;
                rsp_owner_q  <= grant_id;
                last_grant_q <= grant_id;
            end else if (rsp_valid_q && owner_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o      = {rsp_valid_q & rsp_owner_q,
                               rsp_valid_q & ~rsp_owner_q};
    assign rsp_op_result_o  = alu_op_result_i;
    assign rsp_cmp_result_o = alu_cmp_result_i;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU (registered result and compare outputs, 1-cycle latency, clock-enabled) between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1).
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Holds the ALU output register (by gating its clock enable) while a response is unaccepted.
- Routes each result back to the requester that issued it.

Parameters:
- C_XLEN, 32, datapath width.

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  global pipeline clock enable
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester grant; a transfer occurs when valid & ready
- req0_op_left_i / req1_op_left_i  in  C_XLEN  operation left operand
- req0_op_right_i / req1_op_right_i  in  C_XLEN  operation right operand
- req0_op_opcode_i / req1_op_opcode_i  in  `ALUOP_RANGE  ALU operation
- req0_cmp_left_i / req1_cmp_left_i  in  C_XLEN  comparator left
- req0_cmp_right_i / req1_cmp_right_i  in  C_XLEN  comparator right
- req0_cmp_opcode_i / req1_cmp_opcode_i  in  3  ALUCOND code
- alu_clk_en_o  out  1  clock enable to ALU
- alu_op_left_o, alu_op_right_o  out  C_XLEN  muxed operands to ALU
- alu_op_opcode_o  out  `ALUOP_RANGE  muxed opcode
- alu_cmp_left_o, alu_cmp_right_o  out  C_XLEN  muxed comparator operands
- alu_cmp_opcode_o  out  3  muxed comparator opcode
- alu_op_result_i  in  C_XLEN  ALU registered result
- alu_cmp_result_i  in  1  ALU registered compare result
- rsp_valid_o  out  2  one-hot response valid, per requester
- rsp_ready_i  in  2  per-requester response accept
- rsp_op_result_o  out  C_XLEN  = alu_op_result_i (shared bus)
- rsp_cmp_result_o  out  1  = alu_cmp_result_i (shared bus)

Behaviour:
- Reset (async, resetb_i low): rsp_valid_q=0, rsp_owner_q=0, last_grant_q=1. Outputs: req_ready_o=0, rsp_valid_o=0, alu_clk_en_o=0 during reset. A response pending at reset is discarded.
- slot_free = ~rsp_valid_q | rsp_ready_i[rsp_owner_q].
- can_issue = clk_en_i & slot_free.
- Arbitration, combinational, only when can_issue:
  - Exactly one valid requester is granted.
  - Both valid: grant the requester other than last_grant_q.
  - At most one bit of req_ready_o is high; it is high only when that requester's valid is high.
- ALU input mux selects the granted requester. With no grant it selects requester 0 (value is don't-care).
- alu_clk_en_o = clk_en_i & slot_free. This freezes the ALU result/compare registers while a response is unaccepted.
- Registered updates, only when clk_en_i:
  - On issue: rsp_valid_q<=1, rsp_owner_q<=granted id, last_grant_q<=granted id.
  - On accept without new issue: rsp_valid_q<=0.
  - Accept and issue in the same cycle: rsp_valid_q stays 1 and owner updates.
- rsp_valid_o[n] = rsp_valid_q & (rsp_owner_q==n). The response appears exactly 1 clk_en_i cycle after issue, aligned with the ALU output register.
- Throughput: 1 op/cycle sustained when rsp_ready_i is held high, including alternating owners.
- clk_en_i low: no grant, no state change, rsp_valid_o held, ALU frozen.
- rsp_ready_i asserted for the non-owner is ignored.
- Requester inputs must be held stable while valid & ~ready. The arbiter does not register them.

Decomposition:
- Reuse the shared ALU header macros (`ALUOP_RANGE, ALUOP_*, ALUCOND_*).
- Add `ALUARB_NREQ=2 to it.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant from valid vector and last-grant bit, purely combinational). Everything else stays in alu_arbiter.

Test Plan:
- Reset then req0 only, ADD 5+7, rsp_ready=11 -> req_ready_o=01 in cycle 0; cycle 1 rsp_valid_o=01, rsp_op_result_o=12.
- Both valid every cycle, req0 XOR, req1 SUB 10-3, ready high -> grants alternate 01,10,01…, starting with req0; req1 responses carry 7; one response per cycle.
- req1 issues OR 0xF0|0x0F, rsp_ready_i[1] held low 3 cycles while req0 valid -> rsp_op_result_o stays 0xFF, alu_clk_en_o=0, req_ready_o=00. On release, req0 is granted in the same cycle and its result appears next cycle.
- clk_en_i low for 2 cycles with req0 valid and a response pending -> no grant, rsp_valid_o unchanged, alu_clk_en_o=0. Resume continues identically to the no-stall case.
- Compare path: req0 EQ 0x55==0x55, then req1 NE 1!=1 -> rsp_cmp_result_o=1 to req0, then 0 to req1.
- resetb_i asserted mid-flight with rsp_valid_o=10 -> rsp_valid_o=00 immediately (asynchronous). After release, req0 wins the first tie.
